// File: rtl/deser_arbiter.sv
// deser_arbiter
// Round-robin arbiter sharing one serial-to-parallel deserializer among NREQ
// serial sources. A winning source owns the deserializer for exactly one byte
// (8 valid bits, MSB first). The arbiter then waits for the deserializer's
// ready flag, acknowledges it with a single-cycle pulse, and presents the byte
// tagged with its source index on a valid/ack port.
//
// Optional build macro: DESER_ARB_TIMEOUT_EN
//   When defined, a watchdog limits the time spent in WAIT_RDY and DRAIN to
//   TIMEOUT cycles per state visit. On expiry the sticky timeout_err flag is
//   set, the grant is dropped and the FSM returns to IDLE with no byte.
//   When undefined, timeout_err is tied low and the FSM waits indefinitely.
//
// The deserializer must share the reset net: a reset in the middle of a byte
// leaves no way for this block to resynchronise a partially filled shifter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no grant; pick next requester round-robin from ptr
// SHIFT    | grant held; forward granted source's bits until 8 are written
// WAIT_RDY | wait for deser_data_ready, then capture byte and source index
// ACK      | deser_ack_in high for this single cycle
// DRAIN    | wait for deser_data_ready to fall, then release grant
// OUT      | byte_valid high; hold byte/source until byte_ack

module deser_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_100KHz,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] bit_in,
    input  logic [NREQ-1:0] bit_valid,
    output logic [NREQ-1:0] grant,
    output logic            deser_data_in,
    output logic            deser_write_in,
    output logic            deser_ack_in,
    input  logic            deser_data_ready,
    input  logic [7:0]      deser_data_out,
    output logic [7:0]      byte_out,
    output logic [IDW-1:0]  src_out,
    output logic            byte_valid,
    input  logic            byte_ack,
    output logic            timeout_err
);

    // Elaboration-time parameter sanity checks.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("deser_arbiter: NREQ must be in 2..8");
    end
    if (IDW != $clog2(NREQ)) begin : g_bad_idw
        $error("deser_arbiter: IDW must equal clog2(NREQ)");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("deser_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_ACK      = 3'd3,
        S_DRAIN    = 3'd4,
        S_OUT      = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic [2:0]      bit_cnt;

    logic            arb_found;
    logic [IDW-1:0]  arb_idx;

    logic            sel_valid;
    logic            sel_bit;

    logic            load_grant;
    logic            cnt_inc;
    logic            cap_byte;
    logic            set_valid;
    logic            clr_valid;
    logic            drop_grant;
    logic            tmo_fire;

    // Index arithmetic modulo NREQ; NREQ need not be a power of two.
    function automatic logic [IDW-1:0] wrap_idx(input int v);
        return IDW'(v % NREQ);
    endfunction

    // Round-robin search: first set request at or above ptr, wrapping round.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_found && req[wrap_idx(int'(ptr) + i)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_idx(int'(ptr) + i);
            end
        end
    end

    // Mux the granted source's strobe and data using the one-hot grant.
    assign sel_valid     = |(bit_valid & grant);
    assign sel_bit       = |(bit_in & grant);
    assign deser_data_in = sel_bit;
    assign deser_ack_in  = (state == S_ACK);

    // State register.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus single-cycle datapath strobes.
    always_comb begin
        state_nxt      = state;
        load_grant     = 1'b0;
        cnt_inc        = 1'b0;
        cap_byte       = 1'b0;
        set_valid      = 1'b0;
        clr_valid      = 1'b0;
        drop_grant     = 1'b0;
        deser_write_in = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    load_grant = 1'b1;
                    state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                deser_write_in = sel_valid;
                if (sel_valid) begin
                    cnt_inc = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (deser_data_ready) begin
                    cap_byte  = 1'b1;
                    state_nxt = S_ACK;
                end else if (tmo_fire) begin
                    drop_grant = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_ACK: begin
                // Always leave after one cycle; a held ack re-enters the
                // deserializer's send state.
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!deser_data_ready) begin
                    set_valid = 1'b1;
                    state_nxt = S_OUT;
                end else if (tmo_fire) begin
                    drop_grant = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_OUT: begin
                if (byte_ack) begin
                    clr_valid = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant, granted index and round-robin pointer.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else if (load_grant) begin
            grant <= NREQ'(1) << arb_idx;
            gidx  <= arb_idx;
            ptr   <= wrap_idx(int'(arb_idx) + 1);
        end else if (set_valid || drop_grant) begin
            grant <= '0;
        end
    end

    // Valid-bit counter for the current byte.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (load_grant) begin
            bit_cnt <= '0;
        end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Output byte and source tag, captured while data_ready is high.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            byte_out <= '0;
            src_out  <= '0;
        end else if (cap_byte) begin
            byte_out <= deser_data_out;
            src_out  <= gidx;
        end
    end

    // Output valid flag, raised after DRAIN and cleared by byte_ack in OUT.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            byte_valid <= 1'b0;
        end else if (set_valid) begin
            byte_valid <= 1'b1;
        end else if (clr_valid) begin
            byte_valid <= 1'b0;
        end
    end

`ifdef DESER_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr;

    // Watchdog down-counter, reloaded on every state change.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            tmr <= TW'(TIMEOUT - 1);
        end else if (state_nxt != state) begin
            tmr <= TW'(TIMEOUT - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign tmo_fire = ((state == S_WAIT_RDY) || (state == S_DRAIN)) && (tmr == '0);

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (tmo_fire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_deser_arbiter.sv
// Testbench for deser_arbiter: table-driven byte transactions plus hand
// sequences for back-pressure, mid-byte reset and a stuck deserializer.
// Contains a small behavioural deserializer (8-bit MSB-first shifter,
// 2-cycle fill before data_ready, ready cleared by ack_in).

module tb_deser_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk_100KHz = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] bit_in;
    logic [NREQ-1:0] bit_valid;
    logic [NREQ-1:0] grant;
    logic            deser_data_in;
    logic            deser_write_in;
    logic            deser_ack_in;
    logic            deser_data_ready;
    logic [7:0]      deser_data_out;
    logic [7:0]      byte_out;
    logic [IDW-1:0]  src_out;
    logic            byte_valid;
    logic            byte_ack;
    logic            timeout_err;

    always #5 clk_100KHz = ~clk_100KHz;

    deser_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(64)) dut (
        .clk_100KHz       (clk_100KHz),
        .reset            (reset),
        .req              (req),
        .bit_in           (bit_in),
        .bit_valid        (bit_valid),
        .grant            (grant),
        .deser_data_in    (deser_data_in),
        .deser_write_in   (deser_write_in),
        .deser_ack_in     (deser_ack_in),
        .deser_data_ready (deser_data_ready),
        .deser_data_out   (deser_data_out),
        .byte_out         (byte_out),
        .src_out          (src_out),
        .byte_valid       (byte_valid),
        .byte_ack         (byte_ack),
        .timeout_err      (timeout_err)
    );

    // ---------------- source model ----------------
    logic [7:0] src_byte [NREQ];
    logic [2:0] bitpos   [NREQ];
    logic       gap_en;
    logic       phase = 1'b0;

    always @(posedge clk_100KHz) begin
        phase <= ~phase;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant[i]) bitpos[i] <= 3'd0;
            else if (deser_write_in) bitpos[i] <= bitpos[i] + 3'd1;
        end
    end

    always_comb begin
        bit_valid = '0;
        bit_in    = '0;
        for (int i = 0; i < NREQ; i++) begin
            bit_valid[i] = gap_en ? phase : 1'b1;
            bit_in[i]    = src_byte[i][3'd7 - bitpos[i]];
        end
    end

    // ---------------- deserializer model ----------------
    logic       stuck;
    logic [7:0] mdl_sr;
    logic [2:0] mdl_cnt;
    logic [1:0] mdl_fill;

    always @(posedge clk_100KHz) begin
        if (reset) begin
            mdl_sr           <= 8'h00;
            mdl_cnt          <= 3'd0;
            mdl_fill         <= 2'd0;
            deser_data_ready <= 1'b0;
            deser_data_out   <= 8'h00;
        end else begin
            if (deser_write_in) begin
                mdl_sr  <= {mdl_sr[6:0], deser_data_in};
                mdl_cnt <= mdl_cnt + 3'd1;
                if (mdl_cnt == 3'd7) mdl_fill <= 2'd2;
            end
            if (mdl_fill != 2'd0) begin
                mdl_fill <= mdl_fill - 2'd1;
                if (mdl_fill == 2'd1 && !stuck) begin
                    deser_data_ready <= 1'b1;
                    deser_data_out   <= mdl_sr;
                end
            end
            if (deser_ack_in) deser_data_ready <= 1'b0;
        end
    end

    // ---------------- event counters ----------------
    int   wr_cnt     = 0;
    int   ack_cnt    = 0;
    int   ack_double = 0;
    int   rdy_rise   = 0;
    logic ack_prev   = 1'b0;
    logic rdy_prev   = 1'b0;

    always @(posedge clk_100KHz) begin
        ack_prev <= deser_ack_in;
        rdy_prev <= deser_data_ready;
        if (deser_write_in) wr_cnt <= wr_cnt + 1;
        if (deser_ack_in) ack_cnt <= ack_cnt + 1;
        if (deser_ack_in && ack_prev) ack_double <= ack_double + 1;
        if (deser_data_ready && !rdy_prev) rdy_rise <= rdy_rise + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within cycle budget", name);
    endtask

    // Wait for byte_valid and check the transaction it closes.
    task automatic wait_byte(input logic [1:0] es, input logic [7:0] eb, input string name);
        int  w0, a0, d0, r0;
        bit  got;
        w0 = wr_cnt; a0 = ack_cnt; d0 = ack_double; r0 = rdy_rise;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk_100KHz);
            if (byte_valid) got = 1'b1;
        end
        if (!got) begin
            fail_timeout({name, " byte_valid"});
            return;
        end
        check({name, " byte_out"},   byte_out, eb);
        check({name, " src_out"},    src_out, es);
        check({name, " grant_rel"},  grant, 0);
        check({name, " write_cnt"},  wr_cnt - w0, 8);
        check({name, " ack_cnt"},    ack_cnt - a0, 1);
        check({name, " ack_double"}, ack_double - d0, 0);
        check({name, " rdy_rises"},  rdy_rise - r0, 1);
    endtask

    task automatic ack_byte(input string name);
        byte_ack = 1'b1;
        @(negedge clk_100KHz);
        check({name, " valid_clr"}, byte_valid, 0);
        byte_ack = 1'b0;
    endtask

    task automatic load_bytes(input logic [31:0] b);
        for (int i = 0; i < NREQ; i++) src_byte[i] = b[8*i +: 8];
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] bytes;
        bit          gap;
        logic [1:0]  src;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit reached;

        vecs[0] = '{4'b1111, 32'h13121110, 1'b0, 2'd0, 8'h10};
        vecs[1] = '{4'b1111, 32'h13121110, 1'b0, 2'd1, 8'h11};
        vecs[2] = '{4'b1111, 32'h13121110, 1'b0, 2'd2, 8'h12};
        vecs[3] = '{4'b1111, 32'h13121110, 1'b0, 2'd3, 8'h13};
        vecs[4] = '{4'b1111, 32'h13121110, 1'b0, 2'd0, 8'h10};
        vecs[5] = '{4'b0001, 32'h000000A5, 1'b0, 2'd0, 8'hA5};
        vecs[6] = '{4'b0100, 32'h003C0000, 1'b1, 2'd2, 8'h3C};
        vecs[7] = '{4'b1010, 32'h77006600, 1'b0, 2'd3, 8'h77};
        vecs[8] = '{4'b1010, 32'h77006600, 1'b0, 2'd1, 8'h66};

        reset    = 1'b1;
        req      = '0;
        byte_ack = 1'b0;
        gap_en   = 1'b0;
        stuck    = 1'b0;
        load_bytes(32'h0);
        repeat (3) @(negedge clk_100KHz);
        check("rst grant",       grant, 0);
        check("rst byte_valid",  byte_valid, 0);
        check("rst byte_out",    byte_out, 0);
        check("rst src_out",     src_out, 0);
        check("rst write_in",    deser_write_in, 0);
        check("rst ack_in",      deser_ack_in, 0);
        check("rst timeout_err", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk_100KHz);

        // Table-driven transactions: round-robin, single source, gapped, fairness.
        for (int v = 0; v < 9; v++) begin
            load_bytes(vecs[v].bytes);
            gap_en = vecs[v].gap;
            req    = vecs[v].rq;
            wait_byte(vecs[v].src, vecs[v].data, $sformatf("vec%0d", v));
            ack_byte($sformatf("vec%0d", v));
        end
        gap_en = 1'b0;

        // Back-pressure: byte held 20 cycles, competing request must wait.
        load_bytes(32'h0000C35A);
        req = 4'b0001;
        wait_byte(2'd0, 8'h5A, "bp0");
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_100KHz);
            check($sformatf("bp hold%0d", c), {byte_valid, src_out, byte_out, grant},
                  {1'b1, 2'd0, 8'h5A, 4'b0000});
        end
        ack_byte("bp0");
        check("bp grant_idle", grant, 0);
        @(negedge clk_100KHz);
        check("bp grant_next", grant, 4'b0010);
        wait_byte(2'd1, 8'hC3, "bp1");
        req = 4'b0000;
        ack_byte("bp1");

        // Reset after 4 bits of a byte.
        req = 4'b0001;
        begin
            int w0;
            w0 = wr_cnt;
            reached = 1'b0;
            for (int c = 0; c < 300 && !reached; c++) begin
                @(negedge clk_100KHz);
                if (wr_cnt - w0 >= 4) reached = 1'b1;
            end
        end
        if (!reached) fail_timeout("midrst 4 bits");
        check("midrst grant_pre", grant, 4'b0001);
        reset = 1'b1;
        @(negedge clk_100KHz);
        check("midrst grant",       grant, 0);
        check("midrst byte_valid",  byte_valid, 0);
        check("midrst byte_out",    byte_out, 0);
        check("midrst src_out",     src_out, 0);
        check("midrst write_in",    deser_write_in, 0);
        check("midrst ack_in",      deser_ack_in, 0);
        check("midrst timeout_err", timeout_err, 0);
        req   = 4'b0000;
        reset = 1'b0;
        @(negedge clk_100KHz);
        load_bytes(32'h13121110);
        req = 4'b1111;
        wait_byte(2'd0, 8'h10, "postrst");
        req = 4'b0000;
        ack_byte("postrst");

        // Deserializer never raises data_ready.
        stuck = 1'b1;
        req   = 4'b0001;
        begin
            int w0;
            w0 = wr_cnt;
            reached = 1'b0;
            for (int c = 0; c < 300 && !reached; c++) begin
                @(negedge clk_100KHz);
                if (wr_cnt - w0 >= 8) reached = 1'b1;
            end
        end
        if (!reached) fail_timeout("stuck 8 bits");
        req = 4'b0000;
        repeat (60) @(negedge clk_100KHz);
        check("stuck err_early", timeout_err, 0);
        repeat (10) @(negedge clk_100KHz);
`ifdef DESER_ARB_TIMEOUT_EN
        check("stuck timeout_err", timeout_err, 1);
        check("stuck grant",       grant, 0);
`else
        check("stuck timeout_err", timeout_err, 0);
        check("stuck grant",       grant, 4'b0001);
`endif
        check("stuck byte_valid", byte_valid, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_100KHz);
        check("stuck rst err", timeout_err, 0);
        check("stuck rst grant", grant, 0);
        reset = 1'b0;
        stuck = 1'b0;
        @(negedge clk_100KHz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deser_arbiter.md
Name: deser_arbiter

Overview:
- Round-robin arbiter that shares one serial-to-parallel deserializer among NREQ serial sources.
- Grants the deserializer to one source for exactly one byte (8 valid bits), waits for the deserializer's ready flag, acknowledges it with a single-cycle pulse, and presents the byte tagged with its source index on a valid/ack output port.
- Sits between the serial link front-ends and the byte consumer.

Parameters:
- NREQ, 4, number of serial requesters (2..8)
- IDW, 2, source-index width; must equal $clog2(NREQ), minimum 1
- TIMEOUT, 64, cycles to wait for deser_data_ready before the watchdog fires (only with the optional feature)

Ports:
- clk_100KHz  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-source request; level, sampled only in IDLE
- bit_in  input  NREQ  per-source serial data bit
- bit_valid  input  NREQ  per-source bit strobe; one bit per cycle while high
- grant  output  NREQ  one-hot grant, registered
- deser_data_in  output  1  to deserializer data_in; equals bit_in of the granted source
- deser_write_in  output  1  to deserializer write_in
- deser_ack_in  output  1  to deserializer ack_in
- deser_data_ready  input  1  from deserializer data_ready
- deser_data_out  input  8  from deserializer data_out
- byte_out  output  8  captured byte
- src_out  output  IDW  index of the source that produced byte_out
- byte_valid  output  1  byte_out/src_out valid
- byte_ack  input  1  consumer accepts the byte
- timeout_err  output  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- Interface is decided: one clock, clk_100KHz; reset is synchronous and active-high, named reset.
- Reset values: grant=0, deser_write_in=0, deser_ack_in=0, byte_out=0, src_out=0, byte_valid=0, timeout_err=0, bit counter=0, round-robin pointer=0 (source 0 has highest priority first), state=IDLE.
- Reset mid-operation also requires the deserializer to be reset by the same reset net; this block does not resynchronise it.
- IDLE:
  - If req != 0, pick the first set bit searching from ptr upward with wrap-around.
  - Register grant to one-hot, set ptr = winner+1 mod NREQ, clear bit counter, go SHIFT.
  - If req == 0, stay in IDLE with grant=0.
- SHIFT:
  - deser_write_in = bit_valid[g] and deser_data_in = bit_in[g], both combinational from the registered grant.
  - Each cycle with bit_valid[g]=1 increments the counter. On the 8th valid bit go WAIT_RDY.
  - req[g] and all other requests are ignored; grant is held until the byte is complete. No abort path.
  - First accepted bit lands in byte bit 7 (MSB-first).
- WAIT_RDY:
  - deser_write_in=0.
  - On deser_data_ready=1: byte_out <= deser_data_out, src_out <= index of g, go ACK.
- ACK:
  - deser_ack_in=1 for exactly one cycle. It must never be high two consecutive cycles, because a held ack re-enters the deserializer's send state.
  - Go DRAIN.
- DRAIN:
  - Wait for deser_data_ready=0.
  - Then set byte_valid=1, grant=0, go OUT.
- OUT:
  - Hold byte_valid, byte_out and src_out stable until byte_ack=1 is sampled, then clear byte_valid and go IDLE.
  - byte_ack while byte_valid=0 is ignored.
- Latency: after the 8th bit, byte_valid asserts about 6 cycles later (2 cycles deserializer fill, 1 ready, 1 ACK, 1 DRAIN, 1 register).
- Fairness: a source that just won has lowest priority next time. With all req high, grants rotate 0,1,2,3,0...

Optional Feature:
- Macro DESER_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RDY and DRAIN. If it reaches TIMEOUT, set timeout_err=1 (sticky until reset), drop grant, and return to IDLE without producing a byte.
  - The counter clears on every state entry.
- Not defined: no counter; timeout_err is tied to 0 and the block waits indefinitely.

Test Plan:
- Single source: req=4'b0001, bits 1,0,1,0,0,1,0,1 with bit_valid continuous -> byte_valid=1, byte_out=8'hA5, src_out=0; byte_ack -> byte_valid=0 next cycle, state IDLE.
- Round-robin: req=4'b1111, each source sends 8'h10+i -> outputs in order src 0,1,2,3,0 with bytes 10,11,12,13,10.
- Gapped strobes: source 2 sends 8'h3C with bit_valid low on alternate cycles -> byte_out=8'h3C, src_out=2, exactly 8 write_in pulses.
- Back-pressure: hold byte_ack=0 for 20 cycles -> byte_valid, byte_out and src_out stable; req=1 from another source gets no grant until byte_ack.
- Ack pulse: check deser_ack_in high exactly 1 cycle per byte and no second data_ready cycle after DRAIN.
- Reset mid-SHIFT after 4 bits -> all outputs at reset values next cycle. With DESER_ARB_TIMEOUT_EN and deser_data_ready stuck 0 -> timeout_err=1 after 64 cycles and grant=0.
